// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared constants for the PS/2 keyboard receiver and its queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;
    localparam int         FRAME_BITS         = 11;
    localparam int         BIT_CNT_W          = 4;
    localparam logic [7:0] SCAN_BREAK         = 8'hF0;
    localparam logic [7:0] SCAN_EXTEND        = 8'hE0;
    localparam int         DEFAULT_FIFO_DEPTH = 8;
endpackage

`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
// ============================================================================
// Module      : ps2_rx_fifo
// Description : Received scan-code queue with sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr,
    input  logic [7:0] i_wr_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem_q [DEPTH];
    logic [7:0]    w_mem_d [DEPTH];
    logic [AW-1:0] r_head_q, w_head_d;
    logic [AW-1:0] r_tail_q, w_tail_d;
    logic [AW:0]   r_count_q, w_count_d;
    logic          r_ovf_q, w_ovf_d;
    logic          w_pop_en;
    logic          w_wr_en;

    assign o_empty    = (r_count_q == '0);
    assign o_full     = (r_count_q == (AW+1)'(DEPTH));
    assign o_data     = r_mem_q[r_head_q];
    assign o_overflow = r_ovf_q;

    // A pop frees the slot this cycle, so a write into a full queue still lands.
    assign w_pop_en = i_pop && !o_empty;
    assign w_wr_en  = i_wr && (!o_full || w_pop_en);

    always_comb begin
        w_mem_d   = r_mem_q;
        w_head_d  = r_head_q;
        w_tail_d  = r_tail_q;
        w_count_d = r_count_q;
        w_ovf_d   = r_ovf_q;
        if (w_wr_en) begin
            w_mem_d[r_tail_q] = i_wr_data;
            w_tail_d          = r_tail_q + AW'(1);
        end
        if (w_pop_en) begin
            w_head_d = r_head_q + AW'(1);
        end
        case ({w_wr_en, w_pop_en})
            2'b10:   w_count_d = r_count_q + (AW+1)'(1);
            2'b01:   w_count_d = r_count_q - (AW+1)'(1);
            default: w_count_d = r_count_q;
        endcase
        if (i_wr && !w_wr_en) begin
            w_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_q   <= '{default: '0};
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_mem_q   <= w_mem_d;
            r_head_q  <= w_head_d;
            r_tail_q  <= w_tail_d;
            r_count_q <= w_count_d;
            r_ovf_q   <= w_ovf_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
// ============================================================================
// Module      : ps2_keyboard_rx
// Description : PS/2 keyboard frame receiver feeding a scan-code queue.
//               Define PS2_PARITY_CHECK_EN to reject frames with bad parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow
);
    logic [2:0]            r_clk_sync_q, w_clk_sync_d;
    logic [2:0]            r_dat_sync_q, w_dat_sync_d;
    logic                  r_clk_prev_q, w_clk_prev_d;
    logic [BIT_CNT_W-1:0]  r_cnt_q, w_cnt_d;
    logic [FRAME_BITS-2:0] r_shift_q, w_shift_d;
    logic                  r_wr_q, w_wr_d;
    logic [7:0]            r_wr_data_q, w_wr_data_d;

    logic                  w_sample;
    logic                  w_last;
    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_parity_ok;
    logic                  w_frame_ok;
    logic                  w_empty;
    logic                  w_full;

    // Data runs through the same depth of flops so it stays aligned with the clock edge.
    assign w_clk_sync_d = {r_clk_sync_q[1:0], ps2_clk};
    assign w_dat_sync_d = {r_dat_sync_q[1:0], ps2_data};
    assign w_clk_prev_d = r_clk_sync_q[2];
    assign w_sample     = r_clk_prev_q && !r_clk_sync_q[2];
    assign w_last       = (r_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));
    assign w_frame      = {r_dat_sync_q[2], r_shift_q};

`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_ok = ^w_frame[9:1];
`else
    // Parity bit is carried but accepted either way.
    assign w_parity_ok = w_frame[9] | 1'b1;
`endif

    assign w_frame_ok = !w_frame[0] && w_frame[FRAME_BITS-1] && w_parity_ok;

    always_comb begin
        w_cnt_d     = r_cnt_q;
        w_shift_d   = r_shift_q;
        w_wr_d      = 1'b0;
        w_wr_data_d = r_wr_data_q;
        if (w_sample) begin
            if (w_last) begin
                w_cnt_d     = '0;
                w_wr_d      = w_frame_ok;
                w_wr_data_d = w_frame[8:1];
            end else begin
                w_cnt_d   = r_cnt_q + BIT_CNT_W'(1);
                w_shift_d = {r_dat_sync_q[2], r_shift_q[FRAME_BITS-2:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync_q <= '1;
            r_dat_sync_q <= '1;
            r_clk_prev_q <= 1'b1;
            r_cnt_q      <= '0;
            r_shift_q    <= '0;
            r_wr_q       <= 1'b0;
            r_wr_data_q  <= '0;
        end else begin
            r_clk_sync_q <= w_clk_sync_d;
            r_dat_sync_q <= w_dat_sync_d;
            r_clk_prev_q <= w_clk_prev_d;
            r_cnt_q      <= w_cnt_d;
            r_shift_q    <= w_shift_d;
            r_wr_q       <= w_wr_d;
            r_wr_data_q  <= w_wr_data_d;
        end
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr       (r_wr_q),
        .i_wr_data  (r_wr_data_q),
        .i_pop      (!nextdata_n),
        .o_data     (data),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_overflow (overflow)
    );

    assign ready = !w_empty;

    logic w_unused;
    assign w_unused = w_full;
endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
// ============================================================================
// Module      : tb_ps2_keyboard_rx
// Description : Directed and randomized bench for ps2_keyboard_rx against a
//               queue-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_keyboard_rx;
    localparam int DEPTH = 8;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;

    logic       mon_en = 1'b0;
    logic [7:0] mon_q[$];

    ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && ready) mon_q.push_back(data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit flip_par,
                                               input bit bad_stop, input bit bad_start);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        par = par ^ flip_par;
        return {~bad_stop, par, b, bad_start};
    endfunction

    function automatic bit frame_valid(input logic [10:0] f);
        bit ok;
        ok = (f[0] == 1'b0) && (f[10] == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        ok = ok && ($countones(f[9:1]) % 2 == 1);
`endif
        return ok;
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic model_write(input logic [10:0] f);
        if (frame_valid(f)) begin
            if (mq.size() < DEPTH) mq.push_back(f[8:1]);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [10:0] f);
        send_bits(f, 11);
        repeat (10) @(negedge clk);
        model_write(f);
    endtask

    task automatic check_state(input string tag);
        check({tag, "/ready"}, 32'(ready), 32'(mq.size() != 0));
        check({tag, "/overflow"}, 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) check({tag, "/data"}, 32'(data), 32'(mq[0]));
    endtask

    task automatic do_pop;
        @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    initial begin
        int brk;
        logic [10:0] f;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset/ready", 32'(ready), 32'(0));
        check("reset/overflow", 32'(overflow), 32'(0));
        check("reset/data", 32'(data), 32'h00);

        send_frame(make_frame(8'h1C, 0, 0, 0));
        check("one_byte/ready", 32'(ready), 32'(1));
        check("one_byte/data", 32'(data), 32'h1C);
        check("one_byte/overflow", 32'(overflow), 32'(0));
        do_pop();
        check_state("one_byte_pop");

        // Continuous consumption: each byte is visible for exactly one cycle.
        mon_q.delete();
        nextdata_n = 1'b0;
        mon_en = 1'b1;
        send_bits(make_frame(8'hF0, 0, 0, 0), 11);
        send_bits(make_frame(8'h1C, 0, 0, 0), 11);
        repeat (10) @(negedge clk);
        mon_en = 1'b0;
        nextdata_n = 1'b1;
        brk = 0;
        foreach (mon_q[i]) if (mon_q[i] == 8'hF0) brk++;
        check("stream/ready_cycles", 32'(mon_q.size()), 32'(2));
        if (mon_q.size() == 2) begin
            check("stream/first", 32'(mon_q[0]), 32'hF0);
            check("stream/second", 32'(mon_q[1]), 32'h1C);
        end
        check("stream/break_count", 32'(brk), 32'(1));
        check_state("stream_end");

        for (int i = 1; i <= 9; i++) send_frame(make_frame(8'(i), 0, 0, 0));
        check("fill/overflow", 32'(overflow), 32'(1));
        for (int i = 1; i <= 8; i++) begin
            check("drain/data", 32'(data), 32'(i));
            do_pop();
        end
        check("drain/ready", 32'(ready), 32'(0));
        check_state("drain_end");

        send_frame(make_frame(8'h1C, 1, 0, 0));
        check_state("bad_parity");
        while (mq.size() != 0) do_pop();
        check_state("bad_parity_drain");

        send_bits(make_frame(8'hAA, 0, 0, 0), 5);
        @(negedge clk);
        rst = 1'b1;
        ps2_data = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        check_state("midframe_reset");
        send_frame(make_frame(8'h32, 0, 0, 0));
        check("after_reset/ready", 32'(ready), 32'(1));
        check("after_reset/data", 32'(data), 32'h32);
        do_pop();
        check("after_reset/single", 32'(ready), 32'(0));

        send_frame(make_frame(8'h1C, 0, 1, 0));
        check("bad_stop/ready", 32'(ready), 32'(0));
        send_frame(make_frame(8'h24, 0, 0, 0));
        check("recover/data", 32'(data), 32'h24);
        check_state("recover");
        do_pop();

        for (int n = 0; n < 40; n++) begin
            f = make_frame(8'($urandom), ($urandom_range(0, 5) == 0),
                           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            send_frame(f);
            check_state("random_rx");
            if ($urandom_range(0, 2) == 0) begin
                do_pop();
                check_state("random_pop");
            end
        end
        while (mq.size() != 0) begin
            check_state("final_drain");
            do_pop();
        end
        check("final/ready", 32'(ready), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, number of received-byte queue entries; power of two, at least 2.
REQ-002 Port: clk, input, 1 bit, system clock; the only clock; all state updates on its rising edge.
REQ-003 Port: rst, input, 1 bit, reset; synchronous, active-high.
REQ-004 Port: ps2_clk, input, 1 bit, PS/2 device clock; asynchronous to clk.
REQ-005 Port: ps2_data, input, 1 bit, PS/2 device data; asynchronous to clk.
REQ-006 Port: nextdata_n, input, 1 bit, active-low pop request for the queue head.
REQ-007 Port: data, output, 8 bits, scan code at the queue head; valid while ready=1.
REQ-008 Port: ready, output, 1 bit, high while the queue is non-empty.
REQ-009 Port: overflow, output, 1 bit, sticky; set when a valid byte arrives while the queue is full.

Function
REQ-010 ps2_clk SHALL pass through a 3-flop synchroniser on clk; a sample point is a synchronised 1->0 transition, detected one clk after the synchroniser.
REQ-011 A frame SHALL be 11 bits sampled at consecutive sample points: start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-012 A bit counter 0..10 SHALL count samples; on the 11th sample the frame SHALL be checked and the counter SHALL return to 0.
REQ-013 A frame is valid when start=0 and stop=1, plus the parity rule in REQ-024; an invalid frame SHALL be discarded silently with no queue change.
REQ-014 A valid byte SHALL be written to the queue tail in the clk cycle after the 11th sample; ready SHALL rise in the next cycle if the queue was empty.
REQ-015 A pop when nextdata_n=0 and ready=1 SHALL advance the head in that cycle; a pop while empty SHALL be ignored.
REQ-016 Simultaneous write and pop SHALL both take effect; occupancy is unchanged and no overflow is raised even when full.
REQ-017 A write while full without a simultaneous pop SHALL drop the new byte, keep the queue contents and set overflow.
REQ-018 overflow SHALL clear only on rst.
REQ-019 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked so that full and empty are distinct.
REQ-020 data SHALL be driven combinationally from the head entry; its value while ready=0 is don't-care but SHALL be stable (no X).

Reset
REQ-021 rst=1 SHALL clear the bit counter, the shift register, the synchroniser flops (to 1, idle level), the head and tail pointers, and overflow.
REQ-022 After rst: ready=0, overflow=0, data=8'h00.
REQ-023 rst asserted mid-frame SHALL abandon the partial frame; reception SHALL restart at the next start bit after rst deasserts.

Configuration
REQ-024 Macro PS2_PARITY_CHECK_EN: when defined, the XOR of the 8 data bits and the parity bit SHALL equal 1 for a frame to be valid; when undefined, the parity bit SHALL be ignored.

Structure
REQ-025 Package ps2_pkg SHALL hold FRAME_BITS=11, SCAN_BREAK=8'hF0, SCAN_EXTEND=8'hE0, and the default FIFO_DEPTH.
REQ-026 The queue SHALL be a sub-module ps2_rx_fifo (write/pop/full/empty/overflow); the frame receiver SHALL stay in ps2_keyboard_rx.

Verification
REQ-027 Reset, then send frame 0x1C (parity 0) with nextdata_n=1 -> ready=1, data=8'h1C, overflow=0.
REQ-028 Send 0xF0 then 0x1C with nextdata_n held 0 -> ready pulses high for exactly one cycle per byte, data=F0 then 1C; a break-code counter on ready&&data==F0 reads 1.
REQ-029 Send 9 bytes 0x01..0x09 with no pop -> overflow=1, then 8 pops return 01..08 and ready=0.
REQ-030 Send 0x1C with the parity bit flipped -> with PS2_PARITY_CHECK_EN, ready stays 0; without it, data=8'h1C.
REQ-031 Assert rst after 5 bits of a frame, then send full frame 0x32 -> exactly one byte 0x32, ready=1.
REQ-032 Frame 0x1C with stop=0 -> discarded, ready=0; the next good frame 0x24 is received correctly.
